sid_reg_read: RTL and testbench

- Read-side responder of the SID register bus. Envelope and voice blocks only decode writes; this block answers CPU reads.
- Serves POTX (0x19), POTY (0x1A), OSC3 (0x1B) and ENV3 (0x1C).
- Models the bus-decay latch. Reads of write-only addresses return the last written byte until that byte fades to zero.
- Contains the two pot digitisers, which run on the same 1 MHz CLKen tick as the envelopes.

---
 rtl/sid_pkg.sv | 24 ++
 rtl/sid_pot_adc.sv | 61 ++++++
 rtl/sid_reg_read.sv | 127 ++++++++++++
 tb/tb_sid_reg_read.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared SID register map: write offsets per voice, read-only offsets and pot timing.
package sid_pkg;

  localparam logic [4:0] REG_V_CTRL   = 5'h04;
  localparam logic [4:0] REG_V_AD     = 5'h05;
  localparam logic [4:0] REG_V_SR     = 5'h06;
  localparam int         VOICE_STRIDE = 7;

  localparam logic [4:0] REG_POTX = 5'h19;
  localparam logic [4:0] REG_POTY = 5'h1A;
  localparam logic [4:0] REG_OSC3 = 5'h1B;
  localparam logic [4:0] REG_ENV3 = 5'h1C;

  localparam int POT_PERIOD = 512;
  localparam int POT_HALF   = 256;

  // Offsets wrap inside the 5-bit register window.
  function automatic logic [4:0] reg_addr(input int base, input logic [4:0] off);
    int sum;
    sum = base + int'(off);
    return sum[4:0];
  endfunction

endpackage

// File: rtl/sid_pot_adc.sv
// One pot digitiser: comparator synchroniser, saturating charge-time count and
// the value register refreshed at the end of every measurement period.
module sid_pot_adc
  import sid_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clken_i,
  input  logic       phase_hi_i,
  input  logic       period_end_i,
  input  logic       cmp_i,
  output logic [7:0] value_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [7:0] value_q;
  logic [7:0] value_d;

  // Count only while the cap is charging and still below threshold.
  always_comb begin
    count_d = count_q;
    value_d = value_q;
    if (clken_i) begin
      if (!phase_hi_i) begin
        count_d = 8'h00;
      end else if (!sync2_q && (count_q != 8'hFF)) begin
        count_d = count_q + 8'h01;
      end else begin
        count_d = count_q;
      end
      if (period_end_i) begin
        value_d = count_d;
      end else begin
        value_d = value_q;
      end
    end else begin
      count_d = count_q;
      value_d = value_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      count_q <= 8'h00;
      value_q <= 8'h00;
    end else begin
      sync1_q <= cmp_i;
      sync2_q <= sync1_q;
      count_q <= count_d;
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sid_reg_read.sv
// SID read-side responder: pot phase sequencing, bus-decay latch and the
// registered read mux for POTX/POTY/OSC3/ENV3.
module sid_reg_read
  import sid_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int DECAY_TICKS = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLKen,
  input  logic       WR,
  input  logic       RD,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic [7:0] OSC3,
  input  logic [7:0] ENV3,
  input  logic       POTX_CMP,
  input  logic       POTY_CMP,
  output logic       POT_DUMP
);

  localparam logic [4:0]  ADDR_POTX    = reg_addr(BASE_ADDR, REG_POTX);
  localparam logic [4:0]  ADDR_POTY    = reg_addr(BASE_ADDR, REG_POTY);
  localparam logic [4:0]  ADDR_OSC3    = reg_addr(BASE_ADDR, REG_OSC3);
  localparam logic [4:0]  ADDR_ENV3    = reg_addr(BASE_ADDR, REG_ENV3);
  localparam logic [15:0] DECAY_RELOAD = 16'(DECAY_TICKS);

  logic [8:0]  phase_q;
  logic [8:0]  phase_d;
  logic        pot_dump_q;
  logic        period_end_s;
  logic [7:0]  potx_s;
  logic [7:0]  poty_s;
  logic [7:0]  latch_q;
  logic [7:0]  latch_d;
  logic [15:0] decay_q;
  logic [15:0] decay_d;
  logic [7:0]  dout_q;
  logic [7:0]  dout_d;
  logic [7:0]  rd_sel_s;

  assign period_end_s = CLKen && (phase_q == 9'd511);

  sid_pot_adc u_potx (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clken_i      (CLKen),
    .phase_hi_i   (phase_q[8]),
    .period_end_i (period_end_s),
    .cmp_i        (POTX_CMP),
    .value_o      (potx_s)
  );

  sid_pot_adc u_poty (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clken_i      (CLKen),
    .phase_hi_i   (phase_q[8]),
    .period_end_i (period_end_s),
    .cmp_i        (POTY_CMP),
    .value_o      (poty_s)
  );

  always_comb begin
    case (ADDR)
      ADDR_POTX: rd_sel_s = potx_s;
      ADDR_POTY: rd_sel_s = poty_s;
      ADDR_OSC3: rd_sel_s = OSC3;
      ADDR_ENV3: rd_sel_s = ENV3;
      default:   rd_sel_s = latch_q;
    endcase
  end

  // A write reloads the latch and wins over a coincident decay tick.
  always_comb begin
    phase_d = phase_q;
    latch_d = latch_q;
    decay_d = decay_q;
    dout_d  = dout_q;
    if (CLKen) begin
      phase_d = phase_q + 9'd1;
    end else begin
      phase_d = phase_q;
    end
    if (WR) begin
      latch_d = DATA_IN;
      decay_d = DECAY_RELOAD;
    end else if (CLKen && (decay_q != 16'd0)) begin
      decay_d = decay_q - 16'd1;
      if (decay_q == 16'd1) begin
        latch_d = 8'h00;
      end else begin
        latch_d = latch_q;
      end
    end else begin
      latch_d = latch_q;
      decay_d = decay_q;
    end
    if (RD && !WR) begin
      dout_d = rd_sel_s;
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q    <= 9'd0;
      pot_dump_q <= 1'b1;
      latch_q    <= 8'h00;
      decay_q    <= 16'd0;
      dout_q     <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      pot_dump_q <= ~phase_d[8];
      latch_q    <= latch_d;
      decay_q    <= decay_d;
      dout_q     <= dout_d;
    end
  end

  assign DATA_OUT = dout_q;
  assign POT_DUMP = pot_dump_q;

endmodule

// File: tb/tb_sid_reg_read.sv
// Directed bench for sid_reg_read: read-mux table plus pot-period, decay and
// reset sequences with hand-computed expectations.
module tb_sid_reg_read;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLKen = 1'b0;
  logic       WR = 1'b0;
  logic       RD = 1'b0;
  logic [4:0] ADDR = 5'h00;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic [7:0] OSC3 = 8'h00;
  logic [7:0] ENV3 = 8'h00;
  logic       POTX_CMP = 1'b1;
  logic       POTY_CMP = 1'b1;
  logic       POT_DUMP;

  int checks = 0;
  int failures = 0;

  sid_reg_read #(.BASE_ADDR(0), .DECAY_TICKS(2000)) dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .RD(RD), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .OSC3(OSC3), .ENV3(ENV3),
    .POTX_CMP(POTX_CMP), .POTY_CMP(POTY_CMP), .POT_DUMP(POT_DUMP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] osc;
    logic [7:0] env;
    int         reps;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [7:0] act, input int lo, input int hi);
    checks++;
    if ((int'(act) < lo) || (int'(act) > hi)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      CLKen = 1'b1;
      cyc();
      CLKen = 1'b0;
      cyc();
    end
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
    RD = 1'b1;
    ADDR = a;
    cyc();
    RD = 1'b0;
    check8(name, DATA_OUT, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    WR = 1'b1;
    ADDR = a;
    DATA_IN = d;
    cyc();
    WR = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'h1B, 8'h00, 8'hA5, 8'h3C, 1,  8'hA5, "rd_osc3"};
    vecs[1] = '{1'b1, 1'b0, 5'h1C, 8'h00, 8'h77, 8'h3C, 1,  8'h3C, "rd_env3"};
    vecs[2] = '{1'b0, 1'b0, 5'h1B, 8'h00, 8'h12, 8'h34, 10, 8'h3C, "hold_idle"};
    vecs[3] = '{1'b1, 1'b1, 5'h1B, 8'h11, 8'h99, 8'h98, 1,  8'h3C, "rdwr_no_change"};
    vecs[4] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h99, 8'h98, 1,  8'h11, "latch_after_rdwr"};
    vecs[5] = '{1'b1, 1'b0, 5'h1F, 8'h00, 8'h99, 8'h98, 1,  8'h11, "latch_addr1f"};
    vecs[6] = '{1'b1, 1'b0, 5'h19, 8'h00, 8'h99, 8'h98, 1,  8'hFF, "potx_table"};
    vecs[7] = '{1'b1, 1'b0, 5'h1B, 8'h00, 8'h5A, 8'h98, 1,  8'h5A, "rd_osc3_b"};
    vecs[8] = '{1'b0, 1'b1, 5'h05, 8'h22, 8'h00, 8'h00, 1,  8'h5A, "wr_only_hold"};
    vecs[9] = '{1'b1, 1'b0, 5'h05, 8'h00, 8'h00, 8'h00, 1,  8'h22, "rd_latch_22"};

    // Reset state
    RST = 1'b1;
    repeat (3) cyc();
    check8("rst_dout", DATA_OUT, 8'h00);
    check8("rst_dump", {7'd0, POT_DUMP}, 8'h01);
    RST = 1'b0;

    // Idle period: dump pattern and unpopulated POTX
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (POT_DUMP !== (i < 256)) begin
        failures++;
        $display("FAIL pot_dump phase %0d: got %0b expected %0b", i, POT_DUMP, (i < 256));
      end
      if (i == 300) rd_check("potx_first_period", 5'h19, 8'h00);
      tick(1);
    end

    // Measurement period: POTX never charges, POTY charges after 100 counts
    POTX_CMP = 1'b0;
    POTY_CMP = 1'b0;
    tick(256);
    tick(100);
    POTY_CMP = 1'b1;
    tick(156);
    rd_check("potx_saturated", 5'h19, 8'hFF);
    RD = 1'b1; ADDR = 5'h1A; cyc(); RD = 1'b0;
    check_range("poty_100", DATA_OUT, 98, 102);

    // Table-driven read mux / hold / RD+WR vectors
    for (int v = 0; v < 10; v++) begin
      RD = vecs[v].rd;
      WR = vecs[v].wr;
      ADDR = vecs[v].addr;
      DATA_IN = vecs[v].din;
      OSC3 = vecs[v].osc;
      ENV3 = vecs[v].env;
      for (int r = 0; r < vecs[v].reps; r++) begin
        cyc();
        check8(vecs[v].name, DATA_OUT, vecs[v].exp);
      end
      RD = 1'b0;
      WR = 1'b0;
    end

    // Bus decay: exact expiry after 2000 ticks
    wr(5'h05, 8'h5A);
    tick(10);
    rd_check("decay_10", 5'h05, 8'h5A);
    tick(1989);
    rd_check("decay_1999", 5'h05, 8'h5A);
    tick(1);
    rd_check("decay_2000", 5'h05, 8'h00);

    // Rewrite at tick 1999 reloads
    wr(5'h05, 8'h5A);
    tick(1999);
    wr(5'h05, 8'h5A);
    tick(501);
    rd_check("decay_reload_2500", 5'h05, 8'h5A);

    // Write coincident with CLKen: no decrement on the reload tick
    WR = 1'b1; CLKen = 1'b1; ADDR = 5'h1B; DATA_IN = 8'h11;
    cyc();
    WR = 1'b0; CLKen = 1'b0;
    cyc();
    tick(1999);
    rd_check("wr_clken_1999", 5'h00, 8'h11);
    tick(1);
    rd_check("wr_clken_2000", 5'h00, 8'h00);

    // Reset mid-measurement
    RST = 1'b1; cyc(); RST = 1'b0;
    POTX_CMP = 1'b0;
    POTY_CMP = 1'b1;
    tick(300);
    wr(5'h00, 8'h77);
    rd_check("latch_pre_rst", 5'h00, 8'h77);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check8("midrst_dump", {7'd0, POT_DUMP}, 8'h01);
    check8("midrst_dout", DATA_OUT, 8'h00);
    rd_check("midrst_latch", 5'h00, 8'h00);
    rd_check("midrst_potx", 5'h19, 8'h00);
    POTY_CMP = 1'b0;
    tick(256);
    tick(200);
    POTY_CMP = 1'b1;
    tick(56);
    rd_check("post_rst_potx", 5'h19, 8'hFF);
    RD = 1'b1; ADDR = 5'h1A; cyc(); RD = 1'b0;
    check_range("post_rst_poty_200", DATA_OUT, 198, 202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
